// File: rtl/data_bus_slave_pkg.sv
// Shared widths, MMIO offset map and byte-lane helper for the data-bus responder.
// DBUS_PERF_CNT_EN (optional) adds read/write access counters at offsets 5 and 6.
package data_bus_slave_pkg;

  localparam int unsigned DATA_BUS_W      = 32;
  localparam int unsigned DATA_ADDR_BUS_W = 32;
  localparam int unsigned SEL_W           = DATA_BUS_W / 8;
  localparam int unsigned MMIO_OFF_W      = 3;
  localparam int unsigned LED_W           = 16;
  localparam int unsigned CTRL_W          = 2;

  typedef logic [DATA_BUS_W-1:0]      data_bus_t;
  typedef logic [DATA_ADDR_BUS_W-1:0] data_addr_bus_t;
  typedef logic [MMIO_OFF_W-1:0]      mmio_off_t;

  localparam mmio_off_t MMIO_COUNT   = 3'd0;
  localparam mmio_off_t MMIO_COMPARE = 3'd1;
  localparam mmio_off_t MMIO_CTRL    = 3'd2;
  localparam mmio_off_t MMIO_STATUS  = 3'd3;
  localparam mmio_off_t MMIO_LED     = 3'd4;
  localparam mmio_off_t MMIO_RDCNT   = 3'd5;
  localparam mmio_off_t MMIO_WRCNT   = 3'd6;

  localparam int unsigned CTRL_EN_BIT = 0;
  localparam int unsigned CTRL_IE_BIT = 1;

  // MMIO write payload handed from the decoder to register blocks
  typedef struct packed {
    mmio_off_t              off;
    logic [SEL_W-1:0]       sel;
    data_bus_t              wdata;
  } mmio_wr_t;

  // Replace only the byte lanes whose enable bit is set
  function automatic data_bus_t merge_bytes(input data_bus_t old_v,
                                            input data_bus_t new_v,
                                            input logic [SEL_W-1:0] sel);
    data_bus_t r;
    r = old_v;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dbus_timer.sv
// Free-running timer with compare match, pending flag and level interrupt.
// Owns COUNT, COMPARE, CTRL and STATUS; read data is combinational from state.
module dbus_timer
  import data_bus_slave_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en,
  input  mmio_wr_t  wr,
  input  mmio_off_t rd_off,
  output data_bus_t rdata_c,
  output logic      irq_o
);

  data_bus_t         count_q, count_d;
  data_bus_t         compare_q, compare_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              pending_q, pending_d;
  logic              irq_q, irq_d;
  logic              en;

  assign en = ctrl_q[CTRL_EN_BIT];

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;

    if (en) count_d = count_q + DATA_BUS_W'(1);

    if (wr_en) begin
      case (wr.off)
        MMIO_COUNT:   count_d   = merge_bytes(count_q, wr.wdata, wr.sel);
        MMIO_COMPARE: compare_d = merge_bytes(compare_q, wr.wdata, wr.sel);
        MMIO_CTRL:    ctrl_d    = CTRL_W'(merge_bytes(DATA_BUS_W'(ctrl_q), wr.wdata, wr.sel));
        MMIO_STATUS:  if (wr.sel[0] && wr.wdata[0]) pending_d = 1'b0;
        default: ;
      endcase
    end

    // A match in the same cycle as a write-1-clear keeps the flag set
    if (en && (count_q == compare_q)) pending_d = 1'b1;

    irq_d = pending_d & ctrl_d[CTRL_IE_BIT];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '1;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (rd_off)
      MMIO_COUNT:   rdata_c = count_q;
      MMIO_COMPARE: rdata_c = compare_q;
      MMIO_CTRL:    rdata_c = DATA_BUS_W'(ctrl_q);
      MMIO_STATUS:  rdata_c = DATA_BUS_W'(pending_q);
      default:      rdata_c = '0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/data_bus_slave.sv
// CPU data-port responder: word RAM plus MMIO (timer, LED, optional counters).
// Define DBUS_PERF_CNT_EN to add read/write access counters at MMIO offsets 5/6.
module data_bus_slave
  import data_bus_slave_pkg::*;
#(
  parameter int unsigned RAM_AW   = 10,
  parameter logic [3:0]  MMIO_TAG = 4'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 we,
  input  logic [DATA_ADDR_BUS_W-1:0] addr,
  input  logic [DATA_BUS_W-1:0]      data_i,
  input  logic [SEL_W-1:0]           sel,
  output logic [DATA_BUS_W-1:0]      data_o,
  output logic [LED_W-1:0]           led_o,
  output logic                       timer_irq_o
);

  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

  data_bus_t         ram_mem [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx;
  data_bus_t         ram_rdata;
  logic              is_mmio;
  logic              access_rd;
  logic              ram_wr;
  logic              mmio_wr;
  mmio_off_t         mmio_off;
  mmio_wr_t          mmio_wr_pl;
  data_bus_t         timer_rdata;
  data_bus_t         perf_rdata;
  data_bus_t         mmio_rdata;
  logic [LED_W-1:0]  led_q, led_d;
  logic              unused_addr;

  assign is_mmio    = (addr[DATA_ADDR_BUS_W-1 -: 4] == MMIO_TAG);
  assign ram_idx    = addr[RAM_AW+1:2];
  assign mmio_off   = addr[MMIO_OFF_W+1:2];
  assign access_rd  = rst && ce && !we;
  assign ram_wr     = ce && we && !is_mmio;
  assign mmio_wr    = ce && we && is_mmio;
  assign mmio_wr_pl = '{off: mmio_off, sel: sel, wdata: data_i};
  assign unused_addr = ^addr;

  // RAM keeps its contents through reset; reset only blocks the commit
  always_ff @(posedge clk) begin
    if (rst && ram_wr) begin
      for (int b = 0; b < int'(SEL_W); b++) begin
        if (sel[b]) ram_mem[ram_idx][b*8 +: 8] <= data_i[b*8 +: 8];
      end
    end
  end

  assign ram_rdata = ram_mem[ram_idx];

  dbus_timer u_timer (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (mmio_wr),
    .wr      (mmio_wr_pl),
    .rd_off  (mmio_off),
    .rdata_c (timer_rdata),
    .irq_o   (timer_irq_o)
  );

  always_comb begin
    led_d = led_q;
    if (mmio_wr && (mmio_off == MMIO_LED)) begin
      led_d = LED_W'(merge_bytes(DATA_BUS_W'(led_q), data_i, sel));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) led_q <= '0;
    else      led_q <= led_d;
  end

  assign led_o = led_q;

`ifdef DBUS_PERF_CNT_EN
  data_bus_t rd_cnt_q, rd_cnt_d;
  data_bus_t wr_cnt_q, wr_cnt_d;

  // A clearing write wins over the access it is itself counted as
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (ce && !we) rd_cnt_d = rd_cnt_q + DATA_BUS_W'(1);
    if (ce && we)  wr_cnt_d = wr_cnt_q + DATA_BUS_W'(1);
    if (mmio_wr && (|sel) && (mmio_off == MMIO_RDCNT)) rd_cnt_d = '0;
    if (mmio_wr && (|sel) && (mmio_off == MMIO_WRCNT)) wr_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign perf_rdata = (mmio_off == MMIO_RDCNT) ? rd_cnt_q :
                      (mmio_off == MMIO_WRCNT) ? wr_cnt_q : '0;
`else
  assign perf_rdata = '0;
`endif

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      MMIO_COUNT, MMIO_COMPARE, MMIO_CTRL, MMIO_STATUS: mmio_rdata = timer_rdata;
      MMIO_LED:                  mmio_rdata = DATA_BUS_W'(led_q);
      MMIO_RDCNT, MMIO_WRCNT:    mmio_rdata = perf_rdata;
      default:                   mmio_rdata = '0;
    endcase
  end

  assign data_o = access_rd ? (is_mmio ? mmio_rdata : ram_rdata) : '0;

endmodule

// File: doc/data_bus_slave.md
Name: data_bus_slave

Overview:
- Responder for the CPU data-memory port: consumes ce/we/addr/data/sel from the core and returns read data.
- Decodes the address into two regions: a word-addressed RAM and a small MMIO block.
- The MMIO block holds a free-running timer with a compare interrupt and an LED output register.
- Sits in mips_sopc in place of the plain data RAM.

Parameters:
- RAM_AW, 10, log2 of RAM depth in 32-bit words (default 1024 words, 4 KiB).
- MMIO_TAG, 4'h1, value of addr[31:28] that selects the MMIO region.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low: state clears on a rising edge of clk while rst=0.
- ce  in  1  access enable from the core.
- we  in  1  1=write, 0=read; ignored when ce=0.
- addr  in  32  byte address; bits [1:0] are ignored.
- data_i  in  32  write data from the core.
- sel  in  4  byte enables: sel[3]->[31:24], sel[2]->[23:16], sel[1]->[15:8], sel[0]->[7:0].
- data_o  out  32  read data to the core.
- led_o  out  16  LED register contents.
- timer_irq_o  out  1  timer interrupt to the core, level-sensitive.

Behaviour:
- Region decode: MMIO when addr[31:28]==MMIO_TAG, RAM otherwise.
- RAM index is addr[RAM_AW+1:2]; higher address bits alias (wrap), with no error.
- Read path is combinational: data_o is valid in the same cycle as ce=1 && we=0.
  - data_o returns the full word regardless of sel; the core extracts bytes.
  - data_o=0 when ce=0, we=1, or rst=0.
- Writes commit at the rising edge when ce=1 && we=1; only bytes with sel bit set change.
  - sel=4'b0000 is a no-op.
  - Read-after-write to the same address in the next cycle returns the new data.
- RAM contents are not cleared by reset.
- MMIO map (offset = addr[4:2]); unmapped offsets read 0 and ignore writes:
  - 0 COUNT (rw)
  - 1 COMPARE (rw)
  - 2 CTRL (rw): bit0 en, bit1 ie
  - 3 STATUS: bit0 pending; read; write-1-clear
  - 4 LED (rw): bits [15:0]
- MMIO writes honour sel per byte, except STATUS, which uses bit0 when sel[0]=1.
- Timer:
  - When CTRL.en=1, COUNT increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - When CTRL.en=1 and COUNT==COMPARE in a cycle, pending is set at that cycle's edge.
  - timer_irq_o = pending & CTRL.ie, registered-state based with no combinational path from inputs.
- Simultaneous events:
  - A CPU write to COUNT beats the increment; the written value is loaded, not value+1.
  - A compare match and a STATUS write-1-clear in the same cycle leave pending=1 (set wins).
  - A write to COMPARE takes effect in the next cycle's comparison.
- Reset values: COUNT=0, COMPARE=32'hFFFF_FFFF, CTRL=0, pending=0, LED=0, so led_o=0 and timer_irq_o=0.
  - Reset mid-operation aborts any in-flight write in that cycle; the write does not commit.

Optional Feature:
- Macro DBUS_PERF_CNT_EN.
- Defined:
  - Two 32-bit counters count committed reads and committed writes (ce=1 accesses, any region); both wrap.
  - They are readable at MMIO offsets 5 (RDCNT) and 6 (WRCNT).
  - Writing any value to either counter clears it; reset clears both.
- Undefined: offsets 5 and 6 read 0, and no counter logic is synthesized.

Decomposition:
- Shared package/defines file holds:
  - DataBus and DataAddrBus widths.
  - MMIO offset constants: MMIO_COUNT, MMIO_COMPARE, MMIO_CTRL, MMIO_STATUS, MMIO_LED, MMIO_RDCNT, MMIO_WRCNT.
  - CTRL bit positions.
- One sub-module, dbus_timer, holds COUNT/COMPARE/CTRL/pending and the irq. It takes a write strobe, offset, sel and data, and returns read data.
- RAM array and decode stay in data_bus_slave.

Test Plan:
- Byte-lane write: write 32'h1122_3344 to 0x100 with sel=4'hF, then 32'hAAxx_xxxx with sel=4'b1000 -> read 0x100 = 32'hAA22_3344.
- Alias and idle read: write 32'hDEAD_BEEF to 0x0 -> read 0x1000 (RAM_AW=10) = 32'hDEAD_BEEF; ce=0 -> data_o=0.
- Timer irq: COMPARE=5, CTRL=3 with COUNT=0 -> pending and timer_irq_o rise at the edge where COUNT==5; STATUS write 1 -> irq drops next cycle.
- Collision cases:
  - Write COUNT=100 while en=1 -> next read 100.
  - Match and W1C in the same cycle -> pending stays 1.
- Reset: after LED=16'hBEEF and CTRL=3, hold rst=0 for one edge -> led_o=0, timer_irq_o=0, COUNT=0; RAM word at 0x100 is unchanged.
- With DBUS_PERF_CNT_EN: 3 reads and 2 writes -> RDCNT=3 (read excludes itself until its edge), WRCNT=2. Without the macro -> both offsets read 0.
